bp_fe_bp_update_ctrl: RTL and testbench
=======================================

Name: bp_fe_bp_update_ctrl

Overview:
- Write-side driver for the gselect predictor's update port (w_v_i / idx_w_i / correct_i).
- Records every prediction made at fetch (BHT index plus predicted direction) in an in-order in-flight queue.
- When the backend resolves each branch in program order, compares predicted vs actual direction and issues one registered update to the predictor.
- Maintains prediction and accuracy statistics counters.

Parameters:
- bht_idx_width_p, 9, BHT index width; must match the predictor instance.
- inflight_els_p, 8, in-flight queue depth; power of two, ≥2.
- stat_width_p, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- pred_v_i  in  1  fetch made a prediction this cycle
- pred_idx_i  in  bht_idx_width_p  BHT index used for that prediction
- pred_taken_i  in  1  predicted direction (predictor's predict_o)
- pred_ready_o  out  1  queue can accept a prediction
- res_v_i  in  1  oldest in-flight branch resolved
- res_taken_i  in  1  actual direction
- res_ready_o  out  1  a resolution can be accepted
- flush_i  in  1  squash all unresolved in-flight predictions
- w_v_o  out  1  update valid, to predictor w_v_i
- idx_w_o  out  bht_idx_width_p  update index, to predictor idx_w_i
- correct_o  out  1  prediction was correct, to predictor correct_i
- n_pred_o  out  stat_width_p  number of resolved predictions
- n_correct_o  out  stat_width_p  number of correct resolved predictions
- err_underflow_o  out  1  sticky: resolution arrived while the queue was empty

Behaviour:
- Reset (synchronous, reset_i high at a clk_i edge):
  - queue emptied; w_v_o, idx_w_o, correct_o, n_pred_o, n_correct_o, err_underflow_o all 0.
  - pred_ready_o = 1 and res_ready_o = 0 from the first cycle after reset.
  - Reset mid-operation discards all entries with no updates emitted.
- Push: pred_v_i & pred_ready_o writes {pred_idx_i, pred_taken_i} at the tail.
  - pred_ready_o = !full and depends only on registered state; a pop in the same cycle does not free a slot early.
  - pred_v_i while full is dropped; the queue and counters are unchanged.
- Pop: res_v_i & res_ready_o removes the head.
  - res_ready_o = !empty, registered state only; a same-cycle push does not bypass to a pop.
  - res_v_i while empty sets err_underflow_o, which stays set until reset. No update is emitted.
- Update output, 1-cycle latency: in the cycle after a pop, w_v_o = 1, idx_w_o = head idx, correct_o = (head taken == res_taken_i).
  - w_v_o is 0 in every other cycle. One pop produces exactly one update.
- Statistics, updated in the same cycle w_v_o goes high:
  - n_pred_o increments by 1; n_correct_o increments when correct_o = 1.
  - Both saturate at all-ones and never wrap.
- Simultaneous push and pop when neither full nor empty: both take effect; occupancy is unchanged.
- Flush:
  - A resolution in the same cycle is honoured first (its update is still emitted next cycle).
  - All remaining entries are then cleared, and a push in the same cycle is dropped.
  - After the flush: empty, pred_ready_o = 1, res_ready_o = 0.
- Pointers are log2(inflight_els_p)+1 bits wide.
  - Full when the low bits are equal and the MSBs differ; empty when all bits are equal.
  - Pointer wrap-around must be correct across more than inflight_els_p pushes.

Decomposition:
- Shared package bp_fe_bp_pkg:
  - typedef bp_inflight_entry_s {idx, taken}, parameterized by bht_idx_width_p.
  - shared constant for the counter saturation value.
- Sub-module bp_fe_bp_inflight_fifo: circular buffer with push/pop/clear and full/empty flags.
- The top level holds the comparison, the output register, the counters and the error flag.

Test Plan:
- Single branch: push idx=0x05, taken=1; next cycle resolve taken=1 → one cycle later w_v_o=1, idx_w_o=0x05, correct_o=1; n_pred_o=1, n_correct_o=1.
- Mispredict: push idx=0x1FF, taken=0; resolve taken=1 → w_v_o=1, idx_w_o=0x1FF, correct_o=0; n_correct_o unchanged.
- Fill/order/wrap:
  - Push 8 entries with idx 0..7 → pred_ready_o=0 after the 8th; a 9th push is dropped.
  - Resolve all 8 → updates emerge in order with idx 0..7.
  - Repeat with idx 8..23 interleaved push/pop to cross the pointer wrap; the order is preserved.
- Flush: push idx 1, 2, 3; assert flush_i together with a resolve (taken matches) → exactly one update, idx 1, correct_o=1; then res_ready_o=0 and pred_ready_o=1. A push on the flush cycle is lost.
- Underflow and reset: res_v_i=1 while empty → err_underflow_o=1, no w_v_o. Reset mid-stream with 3 entries queued → all outputs 0 and no updates afterwards.
- Saturation: stat_width_p=3, resolve 9 correct branches → n_pred_o and n_correct_o hold at 7.

Source files
------------

// File: rtl/bp_fe_bp_pkg.sv
// Shared constants for the gselect predictor update path.
// Counter saturation value, sliced to width by each user.
package bp_fe_bp_pkg;

    localparam int bp_stat_width_max_gp = 64;
    localparam logic [bp_stat_width_max_gp-1:0] bp_stat_sat_gp = '1;

    localparam int bp_bht_idx_width_gp = 9;
    localparam int bp_inflight_els_gp  = 8;

endpackage

// File: rtl/bp_fe_bp_inflight_fifo.sv
// In-order circular buffer of in-flight predictions.
// Pointers carry one extra wrap bit to tell full from empty.
module bp_fe_bp_inflight_fifo #(
    parameter int width_p = 10,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int addr_w_lp = $clog2(els_p);
    localparam int ptr_w_lp  = addr_w_lp + 1;

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[addr_w_lp-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[addr_w_lp-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[addr_w_lp-1:0] == rd_ptr_q[addr_w_lp-1:0])
                   & (wr_ptr_q[addr_w_lp] != rd_ptr_q[addr_w_lp]);

endmodule

// File: rtl/bp_fe_bp_update_ctrl.sv
// Drives the gselect predictor write port from in-order branch resolutions,
// and keeps saturating prediction / accuracy counters.
module bp_fe_bp_update_ctrl
    import bp_fe_bp_pkg::*;
#(
    parameter int bht_idx_width_p = bp_bht_idx_width_gp,
    parameter int inflight_els_p  = bp_inflight_els_gp,
    parameter int stat_width_p    = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    output logic                       res_ready_o,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic [stat_width_p-1:0]    n_pred_o,
    output logic [stat_width_p-1:0]    n_correct_o,
    output logic                       err_underflow_o
);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       taken;
    } bp_inflight_entry_s;

    localparam logic [stat_width_p-1:0] sat_lp =
        bp_stat_sat_gp[stat_width_p-1:0];

    bp_inflight_entry_s push_ent, head_ent;
    logic full, empty, push, pop;

    logic                       w_v_q, w_v_d;
    logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
    logic                       correct_q, correct_d;
    logic [stat_width_p-1:0]    n_pred_q, n_pred_d;
    logic [stat_width_p-1:0]    n_correct_q, n_correct_d;
    logic                       err_q, err_d;

    // Flush drops a same-cycle push but still honours the pop.
    assign push = pred_v_i & ~full & ~flush_i;
    assign pop  = res_v_i & ~empty;

    assign push_ent.idx   = pred_idx_i;
    assign push_ent.taken = pred_taken_i;

    bp_fe_bp_inflight_fifo #(
        .width_p ($bits(bp_inflight_entry_s)),
        .els_p   (inflight_els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .push_i  (push),
        .data_i  (push_ent),
        .pop_i   (pop),
        .data_o  (head_ent),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        w_v_d       = pop;
        idx_w_d     = '0;
        correct_d   = 1'b0;
        n_pred_d    = n_pred_q;
        n_correct_d = n_correct_q;
        err_d       = err_q | (res_v_i & empty);
        if (pop) begin
            idx_w_d   = head_ent.idx;
            correct_d = (head_ent.taken == res_taken_i);
            if (n_pred_q != sat_lp) n_pred_d = n_pred_q + 1'b1;
            if (correct_d && n_correct_q != sat_lp)
                n_correct_d = n_correct_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_v_q       <= 1'b0;
            idx_w_q     <= '0;
            correct_q   <= 1'b0;
            n_pred_q    <= '0;
            n_correct_q <= '0;
            err_q       <= 1'b0;
        end else begin
            w_v_q       <= w_v_d;
            idx_w_q     <= idx_w_d;
            correct_q   <= correct_d;
            n_pred_q    <= n_pred_d;
            n_correct_q <= n_correct_d;
            err_q       <= err_d;
        end
    end

    assign pred_ready_o    = ~full;
    assign res_ready_o     = ~empty;
    assign w_v_o           = w_v_q;
    assign idx_w_o         = idx_w_q;
    assign correct_o       = correct_q;
    assign n_pred_o        = n_pred_q;
    assign n_correct_o     = n_correct_q;
    assign err_underflow_o = err_q;

endmodule

// File: tb/tb_bp_fe_bp_update_ctrl.sv
// Directed and random checks of the update controller against a
// queue-based reference model; 3-bit counters exercise saturation.
module tb_bp_fe_bp_update_ctrl;

    localparam int IW  = 9;
    localparam int ELS = 8;
    localparam int SW  = 3;
    localparam int SAT = 7;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          pred_v_i;
    logic [IW-1:0] pred_idx_i;
    logic          pred_taken_i;
    logic          pred_ready_o;
    logic          res_v_i;
    logic          res_taken_i;
    logic          res_ready_o;
    logic          flush_i;
    logic          w_v_o;
    logic [IW-1:0] idx_w_o;
    logic          correct_o;
    logic [SW-1:0] n_pred_o;
    logic [SW-1:0] n_correct_o;
    logic          err_underflow_o;

    always #5 clk = ~clk;

    bp_fe_bp_update_ctrl #(
        .bht_idx_width_p (IW),
        .inflight_els_p  (ELS),
        .stat_width_p    (SW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .pred_v_i        (pred_v_i),
        .pred_idx_i      (pred_idx_i),
        .pred_taken_i    (pred_taken_i),
        .pred_ready_o    (pred_ready_o),
        .res_v_i         (res_v_i),
        .res_taken_i     (res_taken_i),
        .res_ready_o     (res_ready_o),
        .flush_i         (flush_i),
        .w_v_o           (w_v_o),
        .idx_w_o         (idx_w_o),
        .correct_o       (correct_o),
        .n_pred_o        (n_pred_o),
        .n_correct_o     (n_correct_o),
        .err_underflow_o (err_underflow_o)
    );

    // Reference model: a queue of {idx, taken} plus scalar statistics.
    int unsigned  q_idx[$];
    bit           q_tk[$];
    bit           m_wv;
    int unsigned  m_idx;
    bit           m_corr;
    int unsigned  m_np, m_nc;
    bit           m_err;
    bit           m_known = 1'b0;
    bit           m_rst;
    int unsigned  n_upd;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit pv, input int unsigned pidx,
                        input bit ptk, input bit rv, input bit rtk,
                        input bit fl, input bit rst);
        int  occ;
        bit  was_full;
        occ = q_idx.size();
        was_full = (occ == ELS);
        if (m_known) begin
            chk("pred_ready", pred_ready_o, !was_full);
            chk("res_ready", res_ready_o, occ != 0);
        end
        reset_i      = rst;
        pred_v_i     = pv;
        pred_idx_i   = pidx[IW-1:0];
        pred_taken_i = ptk;
        res_v_i      = rv;
        res_taken_i  = rtk;
        flush_i      = fl;
        @(posedge clk);
        #1;
        m_rst = rst;
        m_wv  = 1'b0;
        if (rst) begin
            q_idx.delete();
            q_tk.delete();
            m_np = 0; m_nc = 0; m_err = 1'b0;
            m_known = 1'b1;
        end else begin
            if (rv && occ != 0) begin
                m_wv   = 1'b1;
                m_idx  = q_idx.pop_front();
                m_corr = (q_tk.pop_front() == rtk);
                if (m_np < SAT) m_np++;
                if (m_corr && m_nc < SAT) m_nc++;
            end else if (rv) begin
                m_err = 1'b1;
            end
            if (fl) begin
                q_idx.delete();
                q_tk.delete();
            end else if (pv && !was_full) begin
                q_idx.push_back(pidx % (1 << IW));
                q_tk.push_back(ptk);
            end
        end
        if (m_wv) n_upd++;
        chk("w_v", w_v_o, m_wv);
        if (m_wv) begin
            chk("idx_w", idx_w_o, m_idx);
            chk("correct", correct_o, m_corr);
        end
        if (m_rst) begin
            chk("idx_w_rst", idx_w_o, 0);
            chk("correct_rst", correct_o, 0);
        end
        chk("n_pred", n_pred_o, m_np);
        chk("n_correct", n_correct_o, m_nc);
        chk("err_underflow", err_underflow_o, m_err);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input int unsigned idx, input bit tk);
        step(1, idx, tk, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit tk);
        step(0, 0, 0, 1, tk, 0, 0);
    endtask

    initial begin
        int unsigned u0;
        reset_i = 1'b1; pred_v_i = 1'b0; pred_idx_i = '0;
        pred_taken_i = 1'b0; res_v_i = 1'b0; res_taken_i = 1'b0;
        flush_i = 1'b0;
        m_np = 0; m_nc = 0; m_err = 0; m_wv = 0; n_upd = 0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle();

        // Single correct branch
        push(9'h005, 1);
        resolve(1);
        chk("single_idx", idx_w_o, 9'h005);
        chk("single_np", n_pred_o, 1);
        idle();

        // Mispredict
        push(9'h1FF, 0);
        resolve(1);
        chk("mispred_corr", correct_o, 0);
        chk("mispred_nc", n_correct_o, 1);
        idle();

        // Fill, drop the ninth push, drain in order
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ELS; i++) push(i, i[0]);
        chk("full_ready", pred_ready_o, 0);
        push(9'h0AA, 1);
        for (int i = 0; i < ELS; i++) resolve(i[0]);
        idle();

        // Interleave across pointer wrap
        for (int i = 8; i < 12; i++) push(i, 1);
        for (int i = 12; i < 24; i++) step(1, i, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) resolve(0);
        idle();

        // Flush together with a resolve; the same-cycle push is lost
        step(0, 0, 0, 0, 0, 0, 1);
        push(1, 1); push(2, 0); push(3, 1);
        u0 = n_upd;
        step(1, 9'h077, 1, 1, 1, 1, 0);
        chk("flush_idx", idx_w_o, 1);
        idle(); idle();
        chk("flush_one_upd", n_upd - u0, 1);
        chk("flush_res_ready", res_ready_o, 0);
        chk("flush_pred_ready", pred_ready_o, 1);

        // Underflow, then reset mid-stream
        resolve(1);
        chk("underflow", err_underflow_o, 1);
        push(4, 1); push(5, 1); push(6, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_err", err_underflow_o, 0);
        idle();
        resolve(1);
        idle();

        // Saturation at 7 after nine correct branches
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            push(i + 100, 0);
            resolve(0);
        end
        chk("sat_np", n_pred_o, 7);
        chk("sat_nc", n_correct_o, 7);
        step(0, 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 511),
                 $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 400) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
